// File: rtl/user_input_mc.sv
// rtl/user_input_mc.sv - multi-channel button debounce, press/repeat detect, arbiter and event FIFO
//
// Each button channel is debounced. A debounced rising edge raises a pending
// press flag. Channels selected by REPEAT_MASK also raise repeat flags while
// the button stays held. One flag is granted per cycle: the lowest channel
// index wins, and on a single channel a press wins over a repeat. The granted
// event is written into a show-ahead FIFO that the game FSM drains.
//
// Optional build macro: USER_INPUT_SYNC_EN adds a 2-flop input synchroniser.
//
// Ports:
//   main_logic_clk_i      clock for the whole block
//   rst_i                 asynchronous active-low reset
//   btn_i                 raw button levels, active-high, one bit per channel
//   user_event_rd_req_i   pops the FIFO head when user_event_ready_o is high
//   user_event_o          FIFO head code (channel index + 1), 0 when empty
//   user_event_repeat_o   FIFO head was produced by auto-repeat
//   user_event_ready_o    FIFO not empty
//   overflow_o            sticky: an event was merged into an already-set flag

module user_input_mc #(
    parameter int                 N_BTN         = 5,
    parameter int                 DEB_CYCLES    = 250000,
    parameter logic [N_BTN-1:0]   REPEAT_MASK   = N_BTN'(5'b01110),
    parameter int                 REPEAT_DELAY  = 25000000,
    parameter int                 REPEAT_PERIOD = 6250000,
    parameter int                 FIFO_DEPTH    = 4,
    localparam int                EV_W          = $clog2(N_BTN + 1)
) (
    input  logic              main_logic_clk_i,
    input  logic              rst_i,
    input  logic [N_BTN-1:0]  btn_i,
    input  logic              user_event_rd_req_i,
    output logic [EV_W-1:0]   user_event_o,
    output logic              user_event_repeat_o,
    output logic              user_event_ready_o,
    output logic              overflow_o
);

    localparam int DEB_W   = $clog2(DEB_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [DEB_W-1:0] DEB_LAST        = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LOAD_DELAY  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_LOAD_PERIOD = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_FULL        = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] btn_s;

`ifdef USER_INPUT_SYNC_EN
    logic [N_BTN-1:0] sync_q1;
    logic [N_BTN-1:0] sync_q2;

    always_ff @(posedge main_logic_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_i;
            sync_q2 <= sync_q1;
        end
    end

    assign btn_s = sync_q2;
`else
    assign btn_s = btn_i;
`endif

    // ------------------------------------------------------------------
    // Debounce: q follows the sample only after DEB_CYCLES consecutive
    // differing samples; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] deb_q;
    logic [N_BTN-1:0] deb_q_d;
    logic [DEB_W-1:0] deb_cnt [N_BTN];

    always_ff @(posedge main_logic_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            deb_q   <= '0;
            deb_q_d <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_q_d <= deb_q;
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_s[i] != deb_q[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_q[i]   <= ~deb_q[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // rise is seen the cycle after q sets, so pending lands one edge later.
    logic [N_BTN-1:0] rise;
    assign rise = deb_q & ~deb_q_d;

    // ------------------------------------------------------------------
    // Auto-repeat: count down from the press; each zero emits a tick and
    // reloads the period. Masked-off channels keep their counter at zero.
    // ------------------------------------------------------------------
    logic [RPT_W-1:0] rpt_cnt [N_BTN];
    logic [N_BTN-1:0] rpt_tick;

    always_comb begin
        rpt_tick = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rpt_tick[i] = REPEAT_MASK[i] && deb_q[i] && !rise[i] && (rpt_cnt[i] == '0);
        end
    end

    always_ff @(posedge main_logic_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N_BTN; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!REPEAT_MASK[i] || !deb_q[i]) begin
                    rpt_cnt[i] <= '0;
                end else if (rise[i]) begin
                    rpt_cnt[i] <= RPT_LOAD_DELAY;
                end else if (rpt_cnt[i] == '0) begin
                    rpt_cnt[i] <= RPT_LOAD_PERIOD;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and event flags
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] rpt_pending;
    logic [N_BTN-1:0] req;
    logic [N_BTN-1:0] gnt_oh;
    logic [N_BTN-1:0] grant_fresh;
    logic [N_BTN-1:0] grant_rpt;
    logic [N_BTN-1:0] drop;
    logic [EV_W-1:0]  push_code;
    logic             push_rep;
    logic             push;
    logic             pop;
    logic             can_accept;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign pop        = user_event_rd_req_i && (count != '0);
    assign can_accept = (count != CNT_FULL) || pop;
    assign req        = pending | rpt_pending;
    // Isolate the lowest set request bit: channel 0 has top priority.
    assign gnt_oh     = req & (~req + 1'b1);
    assign push       = (req != '0) && can_accept;

    always_comb begin
        push_code   = '0;
        push_rep    = |(gnt_oh & ~pending);
        grant_fresh = push ? (gnt_oh & pending)  : '0;
        grant_rpt   = push ? (gnt_oh & ~pending) : '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (gnt_oh[i]) begin
                push_code = EV_W'(i + 1);
            end
        end
        // A new event only merges if its flag survives this edge.
        drop = (rise & pending & ~grant_fresh) | (rpt_tick & rpt_pending & ~grant_rpt);
    end

    always_ff @(posedge main_logic_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending     <= '0;
            rpt_pending <= '0;
            overflow_o  <= 1'b0;
        end else begin
            pending     <= (pending & ~grant_fresh) | rise;
            rpt_pending <= (rpt_pending & ~grant_rpt) | rpt_tick;
            overflow_o  <= overflow_o | (|drop);
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO, entries are {repeat_flag, code}
    // ------------------------------------------------------------------
    logic [EV_W:0] mem [FIFO_DEPTH];

    always_ff @(posedge main_logic_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {push_rep, push_code};
        end
    end

    always_ff @(posedge main_logic_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign user_event_ready_o  = (count != '0);
    assign user_event_o        = user_event_ready_o ? mem[rd_ptr][EV_W-1:0] : '0;
    assign user_event_repeat_o = user_event_ready_o && mem[rd_ptr][EV_W];

endmodule

// File: tb/tb_user_input_mc.sv
// tb/tb_user_input_mc.sv - self-checking bench for user_input_mc against a queue-based model

module tb_user_input_mc;

    localparam int         N     = 5;
    localparam int         DEB   = 4;
    localparam int         RDLY  = 20;
    localparam int         RPER  = 8;
    localparam int         DEPTH = 4;
    localparam logic [4:0] MASK  = 5'b01110;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn   = '0;
    logic       rd    = 1'b0;
    logic [2:0] ev;
    logic       ev_rep;
    logic       ev_rdy;
    logic       ovf;

    always #5 clk = ~clk;

    user_input_mc #(
        .N_BTN        (N),
        .DEB_CYCLES   (DEB),
        .REPEAT_MASK  (MASK),
        .REPEAT_DELAY (RDLY),
        .REPEAT_PERIOD(RPER),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .main_logic_clk_i   (clk),
        .rst_i              (rst_n),
        .btn_i              (btn),
        .user_event_rd_req_i(rd),
        .user_event_o       (ev),
        .user_event_repeat_o(ev_rep),
        .user_event_ready_o (ev_rdy),
        .overflow_o         (ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: debounce by run length of identical samples,
    // repeats from the age since the debounced rise, a flag array, and a
    // queue of {repeat*8 + code} entries.
    // ------------------------------------------------------------------
    int mq[$];
    bit pend  [N];
    bit rpend [N];
    bit qm    [N];
    bit last  [N];
    int run   [N];
    int rise_e[N];
    int e;
    bit m_ovf;

    always @(posedge clk or negedge rst_n) begin
        bit pev [N];
        bit tk  [N];
        bit pop_m;
        bit can_m;
        bit rep_m;
        int gi;
        int age;
        if (!rst_n) begin
            mq.delete();
            for (int i = 0; i < N; i++) begin
                pend[i] = 0; rpend[i] = 0; qm[i] = 0; last[i] = 0;
                run[i] = 0; rise_e[i] = -1000;
            end
            e = 0;
            m_ovf = 0;
        end else begin
            e++;
            pop_m = rd && (mq.size() > 0);
            can_m = (mq.size() < DEPTH) || pop_m;
            for (int i = 0; i < N; i++) begin
                pev[i] = qm[i] && (rise_e[i] == e - 1);
                age    = e - rise_e[i] - 1;
                tk[i]  = MASK[i] && qm[i] && (age >= RDLY) && (((age - RDLY) % RPER) == 0);
            end
            gi = -1;
            for (int i = 0; i < N; i++) begin
                if (gi < 0 && (pend[i] || rpend[i])) gi = i;
            end
            if (pop_m) void'(mq.pop_front());
            if (gi >= 0 && can_m) begin
                rep_m = !pend[gi];
                mq.push_back((rep_m ? 8 : 0) + gi + 1);
                if (rep_m) rpend[gi] = 0;
                else       pend[gi]  = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (pev[i]) begin
                    if (pend[i]) m_ovf = 1;
                    pend[i] = 1;
                end
                if (tk[i]) begin
                    if (rpend[i]) m_ovf = 1;
                    rpend[i] = 1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (run[i] == 0 || btn[i] != last[i]) run[i] = 1;
                else if (run[i] < 1000) run[i]++;
                last[i] = btn[i];
                if (btn[i] != qm[i] && run[i] >= DEB) begin
                    qm[i] = btn[i];
                    if (btn[i]) rise_e[i] = e;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int exp_rdy;
        int exp_code;
        int exp_rep;
        exp_rdy  = (mq.size() > 0) ? 1 : 0;
        exp_code = exp_rdy ? (mq[0] % 8) : 0;
        exp_rep  = exp_rdy ? (mq[0] / 8) : 0;
        check("model_ready", int'(ev_rdy), exp_rdy);
        check("model_code", int'(ev), exp_code);
        check("model_repeat", int'(ev_rep), exp_rep);
        check("model_overflow", int'(ovf), int'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    initial begin
        int drain_codes[5];
        int seq_ch[6];
        int rd_pct;
        int hold_div;
        bit exp_ev;

        drain_codes = '{2, 3, 4, 5, 2};
        seq_ch      = '{1, 2, 3, 4, 1, 1};
        rd_pct      = 50;
        hold_div    = 8;

        // Reset state
        wait_n(2);
        check("reset_ready", int'(ev_rdy), 0);
        check("reset_code", int'(ev), 0);
        check("reset_overflow", int'(ovf), 0);
        rst_n = 1'b1;
        wait_n(3);

        // Short glitch on channel 1 never becomes an event
        btn[1] = 1'b1;
        wait_n(3);
        btn[1] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            check("glitch_ready", int'(ev_rdy), 0);
        end

        // Single press on channel 2, reads tied high: ready exactly 6 cycles later
        rd = 1'b1;
        btn[2] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            check("press_ready", int'(ev_rdy), (c == 6) ? 1 : 0);
            if (c == 6) begin
                check("press_code", int'(ev), 3);
                check("press_repeat", int'(ev_rep), 0);
            end
            if (c == 10) btn[2] = 1'b0;
        end
        wait_n(10);

        // Simultaneous presses on channels 0 and 3
        btn = 5'b01001;
        for (int c = 1; c <= 10; c++) begin
            step();
            check("simul_ready", int'(ev_rdy), (c == 6 || c == 7) ? 1 : 0);
            if (c == 6) check("simul_first", int'(ev), 1);
            if (c == 7) check("simul_second", int'(ev), 4);
            check("simul_overflow", int'(ovf), 0);
            if (c == 6) btn = 5'b00000;
        end
        wait_n(10);

        // Held channel 1: press, then repeats 20 cycles later and every 8
        btn[1] = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            step();
            exp_ev = (c == 6) || (c == 26) || (c == 34) || (c == 42) || (c == 50) || (c == 58);
            check("hold_ready", int'(ev_rdy), int'(exp_ev));
            if (exp_ev) begin
                check("hold_code", int'(ev), 2);
                check("hold_repeat", int'(ev_rep), (c == 6) ? 0 : 1);
            end
            if (c == 60) btn[1] = 1'b0;
        end
        wait_n(10);

        // Fill the FIFO without reading, then merge a second ch1 press
        rd = 1'b0;
        for (int k = 0; k < 6; k++) begin
            btn[seq_ch[k]] = 1'b1;
            wait_n(5);
            btn[seq_ch[k]] = 1'b0;
            wait_n(5);
        end
        step();
        check("full_overflow", int'(ovf), 1);
        check("full_model_overflow", int'(m_ovf), 1);
        check("full_model_depth", mq.size(), 4);
        for (int k = 0; k < 5; k++) begin
            check("drain_ready", int'(ev_rdy), 1);
            check("drain_code", int'(ev), drain_codes[k]);
            check("drain_repeat", int'(ev_rep), 0);
            rd = 1'b1;
            step();
            rd = 1'b0;
        end
        check("drain_empty", int'(ev_rdy), 0);

        // Async reset with three queued entries
        btn = 5'b00111;
        wait_n(6);
        btn = 5'b00000;
        wait_n(10);
        check("preq_ready", int'(ev_rdy), 1);
        check("preq_code", int'(ev), 1);
        check("preq_model_depth", mq.size(), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", int'(ev_rdy), 0);
        check("async_code", int'(ev), 0);
        check("async_overflow", int'(ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("empty_rd_ready", int'(ev_rdy), 0);
            check("empty_rd_code", int'(ev), 0);
        end

        // Randomised traffic with varying read pressure and hold lengths
        for (int c = 0; c < 4000; c++) begin
            if ((c % 400) == 0) begin
                rd_pct   = $urandom_range(0, 100);
                hold_div = ($urandom_range(0, 1) == 1) ? 8 : 40;
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, hold_div - 1) == 0) btn[i] = ~btn[i];
            end
            rd = ($urandom_range(0, 99) < rd_pct);
            if (c == 2000) rst_n = 1'b0;
            if (c == 2001) rst_n = 1'b1;
            step();
        end
        btn = '0;
        rd  = 1'b1;
        wait_n(40);
        check("final_empty", int'(ev_rdy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
